// File: rtl/lfsr_pkg.sv
// Shared types and default constants for the LFSR random-word generator.
package lfsr_pkg;

   localparam logic [15:0] LFSR_DEF_TAPS = 16'h002D;
   localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;

   typedef enum logic [0:0] {
      LFSR_FILL = 1'b0,
      LFSR_HOLD = 1'b1
   } lfsr_state_t;

   // A 1-bit word still needs a 1-bit counter.
   function automatic int lfsr_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Output word handshake between lfsr_gen (master) and its consumer (slave).
interface lfsr_gen_if #(
   parameter int OUT_W = 16
);
   logic [OUT_W-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register: right shift, feedback XOR enters the MSB.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEF_SEED)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] state,
   output logic             out_bit
);

   logic fb;

   assign fb      = ^(state & TAPS);
   assign out_bit = state[0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= SEED;
      end else if (load) begin
         state <= load_val;
      end else if (step) begin
         state <= {fb, state[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/lfsr_gen.sv
// Random word generator: collects OUT_W LFSR bits, then holds the word until accepted.
// Define LFSR_GEN_LOCKUP_GUARD_EN to replace any all-zero state or zero seed with SEED.
//
// state | meaning
// FILL  | stepping once per enabled cycle, bit k of the word goes to out_data[k]
// HOLD  | word complete, out_valid high, LFSR frozen until out_valid & out_ready
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = WIDTH'(LFSR_DEF_TAPS),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(LFSR_DEF_SEED),
   parameter int               OUT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] state,
   lfsr_gen_if.master       bus
);

   localparam int               CNT_W    = lfsr_cnt_w(OUT_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

   if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH out of range 4..32");
   end
   if (OUT_W < 1 || OUT_W > 32) begin : g_bad_out_w
      $error("lfsr_gen: OUT_W out of range 1..32");
   end
   if (TAPS == '0) begin : g_bad_taps
      $error("lfsr_gen: TAPS must be nonzero");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: SEED must be nonzero");
   end

   lfsr_state_t      fsm_q;
   logic [CNT_W-1:0] cnt_q;
   logic [OUT_W-1:0] word_q;
   logic             valid_q;

   logic             hs;
   logic             in_fill;
   logic             zero_fix;
   logic             core_load;
   logic             step;
   logic             out_bit;
   logic [WIDTH-1:0] load_val;

   assign hs      = valid_q & bus.out_ready;
   assign in_fill = (fsm_q == LFSR_FILL);

`ifdef LFSR_GEN_LOCKUP_GUARD_EN
   // A zero state would lock the LFSR forever; the recovery cycle takes no step.
   assign zero_fix = in_fill && (state == '0);
   assign load_val = (seed_load && (seed_in != '0)) ? seed_in : SEED;
`else
   assign zero_fix = 1'b0;
   assign load_val = seed_in;
`endif

   assign core_load = seed_load | zero_fix;
   assign step      = en & in_fill & ~core_load;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .step     (step),
      .load     (core_load),
      .load_val (load_val),
      .state    (state),
      .out_bit  (out_bit)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fsm_q   <= LFSR_FILL;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else if (seed_load) begin
         // Any partial or held word is dropped; a coincident handshake still counts.
         fsm_q   <= LFSR_FILL;
         cnt_q   <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         case (fsm_q)
            LFSR_FILL: begin
               if (step) begin
                  word_q[cnt_q] <= out_bit;
                  if (cnt_q == CNT_LAST) begin
                     cnt_q   <= '0;
                     fsm_q   <= LFSR_HOLD;
                     valid_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
            end
            LFSR_HOLD: begin
               if (hs) begin
                  fsm_q   <= LFSR_FILL;
                  cnt_q   <= '0;
                  valid_q <= 1'b0;
               end
            end
            default: begin
               fsm_q   <= LFSR_FILL;
               cnt_q   <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_data  = word_q;
   assign bus.out_valid = valid_q;

endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16: LFSR state width, legal range 4..32.
REQ-002 The module SHALL have parameter TAPS, default 16'h002D: feedback mask, where bit i set means state[i] enters the XOR.
REQ-003 The module SHALL have parameter SEED, default 16'hACE1: reset and recovery state, nonzero.
REQ-004 The module SHALL have parameter OUT_W, default 16: output word width, legal range 1..32.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The module SHALL have port en, input, 1 bit: permits LFSR stepping.
REQ-008 The module SHALL have port seed_load, input, 1 bit: single-cycle request to load seed_in.
REQ-009 The module SHALL have port seed_in, input, WIDTH bits: the new state for seed_load.
REQ-010 The module SHALL have port out_data, output, OUT_W bits: the assembled random word.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-013 The module SHALL have port state, output, WIDTH bits: the current LFSR state, for debug.

Function
REQ-014 Each step SHALL compute fb = XOR of state[i] over all TAPS[i]=1, then state <= {fb, state[WIDTH-1:1]}, with emitted bit = state[0] before the shift.
REQ-015 The FSM SHALL have states FILL and HOLD.
- FILL: one step per cycle while en=1; no step while en=0.
- A bit counter tracks steps taken.
REQ-016 The emitted bit of the k-th step of a word, k=0..OUT_W-1, SHALL be written into out_data[k].
REQ-017 On the OUT_W-th step, the FSM SHALL go to HOLD, with out_valid=1 on the following cycle; latency is OUT_W enabled cycles from the previous handshake.
REQ-018 In HOLD, out_data and out_valid SHALL be stable and the LFSR SHALL not step, regardless of en.
REQ-019 The handshake (out_valid & out_ready) SHALL return the FSM to FILL with counter 0, and out_valid SHALL be 0 the next cycle.
REQ-020 Stepping in the handshake cycle SHALL NOT occur, and no back-to-back words are produced.
REQ-021 seed_load SHALL take priority over a step in the same cycle.
- state <= seed_in, counter <= 0, FSM <= FILL, out_valid <= 0.
- A partial or held word is discarded.
REQ-022 seed_load coinciding with a handshake SHALL count as an accepted handshake, and the load still applies.
REQ-023 The counter SHALL wrap only via the FILL->HOLD transition and SHALL never exceed OUT_W-1.
REQ-024 en deasserted mid-word SHALL freeze the counter and partial word, and stepping SHALL resume without loss when en returns to 1.

Reset
REQ-025 On reset_n=0, the module SHALL asynchronously set state=SEED, counter=0, FSM=FILL, out_valid=0 and out_data=0.
REQ-026 Reset mid-word SHALL discard all progress, and the first step after release SHALL start from SEED.

Configuration
REQ-027 LFSR_GEN_LOCKUP_GUARD_EN defined:
- A seed_in of all zeros on seed_load SHALL load SEED instead.
- An all-zero state detected in FILL SHALL be replaced by SEED on the next cycle, without a step.
REQ-028 LFSR_GEN_LOCKUP_GUARD_EN undefined:
- seed_in=0 SHALL be loaded verbatim.
- The LFSR SHALL remain at 0, emitting 0 bits, while words still complete normally.

Structure
REQ-029 A shared package lfsr_pkg SHALL hold the FSM state enum lfsr_state_t and the default constants LFSR_DEF_TAPS=16'h002D and LFSR_DEF_SEED=16'hACE1.
REQ-030 One sub-module, lfsr_core (the state register plus feedback XOR, with step and load inputs), SHALL be instantiated, and lfsr_gen SHALL own the FSM, counter and word buffer.
REQ-031 Illegal parameters (WIDTH or OUT_W out of range, TAPS=0, SEED=0) SHALL raise an elaboration-time error.

Verification
REQ-032 The bench SHALL apply reset with defaults, then en=1 for 1 cycle, and check state 16'hACE1 -> 16'h5670 and out_data[0]=1.
REQ-033 The bench SHALL hold en=1 and out_ready=1, and check out_valid rises after 16 enabled cycles, is high for 1 cycle, and out_data matches a C-model word.
REQ-034 The bench SHALL hold out_ready=0 for 10 cycles in HOLD, and check out_data stable, state unchanged, then handshake -> next word continues the sequence seamlessly.
REQ-035 The bench SHALL assert seed_load with seed_in=16'h0001 at bit 7 of a word, and check out_valid=0, state=16'h0001, and the next word is computed from 16'h0001.
REQ-036 The bench SHALL assert seed_load with seed_in=0 and check state becomes 16'hACE1 with the guard on, and state stays 0 with the guard off.
REQ-037 The bench SHALL run 65535 steps from SEED and check state returns to 16'hACE1, never reaches 0, and this does not happen earlier.
